// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle for the receive FIFO. The UART-facing signals carry the
// UART_ prefix; the unprefixed ones face ModBusASCII and mirror the UART's
// own RxBuf/RxRdy/RxErr/Read_RxBuf handshake.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          UART_RxBuf;
  logic                UART_RxRdy;
  logic                UART_RxErr;
  logic                UART_Read_RxBuf;
  logic [7:0]          RxBuf;
  logic                RxRdy;
  logic                RxErr;
  logic                Read_RxBuf;
  logic                Overflow;
  logic                Clr_Overflow;
  logic [DEPTH_LOG2:0] Count;

  // FIFO side
  modport slave (
    input  UART_RxBuf, UART_RxRdy, UART_RxErr, Read_RxBuf, Clr_Overflow,
    output UART_Read_RxBuf, RxBuf, RxRdy, RxErr, Overflow, Count
  );

  // Environment side (UART model plus consumer)
  modport master (
    output UART_RxBuf, UART_RxRdy, UART_RxErr, Read_RxBuf, Clr_Overflow,
    input  UART_Read_RxBuf, RxBuf, RxRdy, RxErr, Overflow, Count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: drains the UART holding register into a small
// FIFO of {err, data} entries and re-presents it with a first-word
// fall-through handshake, plus sticky Overflow and an entry Count.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic          clk,
  input  logic          Reset,
  uart_rx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  ack_q;
  logic [8:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic       push_req, push, pop, drop, full, empty;
  logic [8:0] head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A byte is offered only when the FSM is idle; when full it still gets
  // in if a pop frees the slot on the same edge, otherwise it is dropped.
  assign push_req = (state_q == IDLE) && bus.UART_RxRdy;
  assign pop      = bus.Read_RxBuf && !empty;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Capture FSM next-state: sample, acknowledge for one cycle, then give the
  // UART one cycle to drop RxRdy before looking again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.UART_RxRdy) state_d = ACK;
      ACK:     state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and the registered acknowledge pulse (high exactly in ACK).
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ACK);
    end
  end

  // Pointer, count and sticky-overflow next-state.
  always_comb begin
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A drop on the same cycle as a clear leaves the flag set.
    if (drop)                  overflow_d = 1'b1;
    else if (bus.Clr_Overflow) overflow_d = 1'b0;
  end

  // Pointer, count and overflow registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write; contents need no reset because Count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.UART_RxErr, bus.UART_RxBuf};
  end

  // Fall-through read of the head entry, forced to zero while empty so the
  // outputs are defined straight after reset.
  assign head = mem_q[rptr_q];

  assign bus.RxBuf           = empty ? 8'h00 : head[7:0];
  assign bus.RxErr           = empty ? 1'b0  : head[8];
  assign bus.RxRdy           = !empty;
  assign bus.UART_Read_RxBuf = ack_q;
  assign bus.Overflow        = overflow_q;
  assign bus.Count           = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a table of push vectors with the
// expected Count after each, a queue scoreboard checked on every pop, and
// hand-written sequences for the multi-cycle corner cases.
module tb_uart_rx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         exp_count;
    logic       exp_ovf;
  } push_vec_t;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb_q[$];
  int model_count;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    sb_q.delete();
    model_count = 0;
  endtask

  // Present one byte like the UART does, hold it until acknowledged, then
  // drop RxRdy and let the FSM return to IDLE.
  task automatic push_byte(input logic err, input logic [7:0] data);
    int n;
    bus.UART_RxBuf = data;
    bus.UART_RxErr = err;
    bus.UART_RxRdy = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.UART_Read_RxBuf && n < 8);
    if (!bus.UART_Read_RxBuf) chk("ack_timeout", 0, 1);
    if (model_count < DEPTH) begin
      sb_q.push_back({err, data});
      model_count++;
    end
    bus.UART_RxRdy = 1'b0;
    tick();
    tick();
  endtask

  // Compare the head against the scoreboard, then pop it.
  task automatic pop_check(input string name);
    logic [8:0] exp;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      exp = sb_q.pop_front();
      chk({name, "_rdy"}, int'(bus.RxRdy), 1);
      chk({name, "_data"}, int'(bus.RxBuf), int'(exp[7:0]));
      chk({name, "_err"}, int'(bus.RxErr), int'(exp[8]));
      model_count--;
    end
    bus.Read_RxBuf = 1'b1;
    tick();
    bus.Read_RxBuf = 1'b0;
  endtask

  push_vec_t vecs[17];
  int acks;

  initial begin
    bus.UART_RxBuf   = 8'h00;
    bus.UART_RxRdy   = 1'b0;
    bus.UART_RxErr   = 1'b0;
    bus.Read_RxBuf   = 1'b0;
    bus.Clr_Overflow = 1'b0;
    Reset = 1'b0;
    model_count = 0;

    for (int i = 0; i < 17; i++) begin
      vecs[i].err       = 1'b0;
      vecs[i].data      = (i < 16) ? 8'(i) : 8'hAA;
      vecs[i].exp_count = (i < 16) ? i + 1 : 16;
      vecs[i].exp_ovf   = (i == 16);
    end

    // Reset state
    do_reset();
    chk("rst_count", int'(bus.Count), 0);
    chk("rst_rdy", int'(bus.RxRdy), 0);
    chk("rst_rxbuf", int'(bus.RxBuf), 0);
    chk("rst_rxerr", int'(bus.RxErr), 0);
    chk("rst_ovf", int'(bus.Overflow), 0);
    chk("rst_ack", int'(bus.UART_Read_RxBuf), 0);

    // 1: single byte held for two cycles -> one ack pulse, byte visible
    bus.UART_RxBuf = 8'h3A;
    bus.UART_RxErr = 1'b0;
    bus.UART_RxRdy = 1'b1;
    acks = 0;
    tick();
    chk("t1_ack_first", int'(bus.UART_Read_RxBuf), 1);
    chk("t1_rdy", int'(bus.RxRdy), 1);
    chk("t1_data", int'(bus.RxBuf), 8'h3A);
    chk("t1_count", int'(bus.Count), 1);
    acks += int'(bus.UART_Read_RxBuf);
    tick();
    acks += int'(bus.UART_Read_RxBuf);
    bus.UART_RxRdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acks += int'(bus.UART_Read_RxBuf);
    end
    chk("t1_ack_pulses", acks, 1);
    chk("t1_count_after", int'(bus.Count), 1);
    sb_q.push_back({1'b0, 8'h3A});
    model_count = 1;
    pop_check("t1_pop");
    chk("t1_empty", int'(bus.RxRdy), 0);

    // 2: fill from the vector table, then one byte too many
    for (int i = 0; i < 17; i++) begin
      push_byte(vecs[i].err, vecs[i].data);
      chk($sformatf("t2_count_%0d", i), int'(bus.Count), vecs[i].exp_count);
      chk($sformatf("t2_ovf_%0d", i), int'(bus.Overflow), int'(vecs[i].exp_ovf));
    end
    for (int i = 0; i < 16; i++) pop_check($sformatf("t2_pop_%0d", i));
    chk("t2_empty_rdy", int'(bus.RxRdy), 0);
    chk("t2_empty_count", int'(bus.Count), 0);
    chk("t2_ovf_sticky", int'(bus.Overflow), 1);
    bus.Clr_Overflow = 1'b1;
    tick();
    bus.Clr_Overflow = 1'b0;
    chk("t2_ovf_clr", int'(bus.Overflow), 0);

    // 3: full FIFO, push and pop on the same edge
    for (int i = 0; i < 16; i++) push_byte(1'b0, 8'h10 + 8'(i));
    chk("t3_full", int'(bus.Count), 16);
    chk("t3_head", int'(bus.RxBuf), int'(sb_q[0][7:0]));
    void'(sb_q.pop_front());
    bus.UART_RxBuf = 8'h55;
    bus.UART_RxErr = 1'b0;
    bus.UART_RxRdy = 1'b1;
    bus.Read_RxBuf = 1'b1;
    tick();
    bus.Read_RxBuf = 1'b0;
    sb_q.push_back({1'b0, 8'h55});
    chk("t3_ack", int'(bus.UART_Read_RxBuf), 1);
    chk("t3_count", int'(bus.Count), 16);
    chk("t3_ovf", int'(bus.Overflow), 0);
    bus.UART_RxRdy = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) pop_check($sformatf("t3_pop_%0d", i));
    chk("t3_empty", int'(bus.RxRdy), 0);

    // 4: error flag travels with its byte
    push_byte(1'b1, 8'h41);
    push_byte(1'b0, 8'h42);
    pop_check("t4_pop_41");
    pop_check("t4_pop_42");

    // 5: pop while empty is ignored
    bus.Read_RxBuf = 1'b1;
    tick();
    tick();
    bus.Read_RxBuf = 1'b0;
    chk("t5_count", int'(bus.Count), 0);
    chk("t5_rdy", int'(bus.RxRdy), 0);
    push_byte(1'b0, 8'h77);
    chk("t5_count_push", int'(bus.Count), 1);
    pop_check("t5_pop");

    // 6: reset during ACK with three entries stored
    push_byte(1'b0, 8'h01);
    push_byte(1'b0, 8'h02);
    bus.UART_RxBuf = 8'h03;
    bus.UART_RxRdy = 1'b1;
    tick();
    chk("t6_in_ack", int'(bus.UART_Read_RxBuf), 1);
    chk("t6_count3", int'(bus.Count), 3);
    Reset = 1'b1;
    tick();
    chk("t6_count", int'(bus.Count), 0);
    chk("t6_rdy", int'(bus.RxRdy), 0);
    chk("t6_ack", int'(bus.UART_Read_RxBuf), 0);
    chk("t6_ovf", int'(bus.Overflow), 0);
    Reset = 1'b0;
    bus.UART_RxRdy = 1'b0;
    sb_q.delete();
    model_count = 0;
    tick();
    push_byte(1'b0, 8'h99);
    pop_check("t6_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
